// File: rtl/dlart_multi_if.sv
// CPU register-access bus and per-channel host byte links of dlart_multi, parameterised by channel count.
interface dlart_multi_if #(parameter int NCH = 1);
    logic [21:0]      bus_addr;
    logic             bus_rd;
    logic             bus_wr;
    logic             bus_byte;
    logic [15:0]      bus_wdata;
    logic [15:0]      bus_rdata;
    logic             bus_hit;
    logic [NCH-1:0]   rx_irq;
    logic [NCH-1:0]   tx_irq;
    logic [NCH-1:0]   h_rx_valid;
    logic [8*NCH-1:0] h_rx_data;
    logic [NCH-1:0]   h_rx_ready;
    logic [NCH-1:0]   h_tx_valid;
    logic [8*NCH-1:0] h_tx_data;
    logic [NCH-1:0]   h_tx_ready;

    modport master (
        output bus_addr, bus_rd, bus_wr, bus_byte, bus_wdata, h_rx_valid, h_rx_data, h_tx_ready,
        input  bus_rdata, bus_hit, rx_irq, tx_irq, h_rx_ready, h_tx_valid, h_tx_data
    );

    modport slave (
        input  bus_addr, bus_rd, bus_wr, bus_byte, bus_wdata, h_rx_valid, h_rx_data, h_tx_ready,
        output bus_rdata, bus_hit, rx_irq, tx_irq, h_rx_ready, h_tx_valid, h_tx_data
    );
endinterface

// File: rtl/dlart_multi.sv
// N-channel DL11-style console unit: RCSR/RBUF/XCSR/XBUF per channel over RX/TX byte FIFOs; DLART_LOOPBACK_EN adds XCSR MAINT loopback.
// Register reads return one cycle after the strobe; host links are valid/ready, full RX deasserts ready and full TX drops XBUF writes.

module dlart_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_x2,
    input  logic       rstb,
    input  logic       push,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;

    // Extra pointer bit separates full from empty when the index bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr == {~rptr[AW], rptr[AW-1:0]});
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_x2) begin
        if (!rstb) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + (AW+1)'(1);
            if (pop && !empty)
                rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_x2) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= push_dat;
    end
endmodule

module dlart_multi #(
    parameter int          NCH      = 1,
    parameter logic [21:0] BASE     = 22'o17777560,
    parameter int          STRIDE   = 8,
    parameter int          RX_DEPTH = 4,
    parameter int          TX_DEPTH = 4
) (
    input logic          clk_x2,
    input logic          rstb,
    dlart_multi_if.slave io
);
    logic [NCH-1:0]    chan_hit;
    logic              any_hit;
    logic [16*NCH-1:0] rd_words;
    logic [15:0]       rd_mux;
    logic [NCH-1:0]    rx_irq_v;
    logic [NCH-1:0]    tx_irq_v;
    logic [NCH-1:0]    rx_ready_v;
    logic [NCH-1:0]    tx_valid_v;
    logic [8*NCH-1:0]  tx_data_v;

    always_comb begin
        chan_hit = '0;
        for (int c = 0; c < NCH; c++) begin
            if (({1'b0, io.bus_addr} >= 23'(BASE) + 23'(c * STRIDE)) &&
                ({1'b0, io.bus_addr} <= 23'(BASE) + 23'(c * STRIDE + 7)))
                chan_hit[c] = 1'b1;
        end
    end

    assign any_hit = |chan_hit;

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NCH; c++) begin
            if (chan_hit[c])
                rd_mux = rd_mux | rd_words[16*c +: 16];
        end
    end

    always_ff @(posedge clk_x2) begin
        if (!rstb) begin
            io.bus_rdata <= '0;
            io.bus_hit   <= 1'b0;
        end else begin
            io.bus_hit   <= io.bus_rd && any_hit;
            io.bus_rdata <= (io.bus_rd && any_hit) ? rd_mux : 16'h0000;
        end
    end

    assign io.rx_irq     = rx_irq_v;
    assign io.tx_irq     = tx_irq_v;
    assign io.h_rx_ready = rx_ready_v;
    assign io.h_tx_valid = tx_valid_v;
    assign io.h_tx_data  = tx_data_v;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [1:0]  off;
        logic        rd_sel;
        logic        wr_lo;
        logic        rie;
        logic        xie;
        logic        maint;
        logic        loop;
        logic        rx_push;
        logic        rx_pop;
        logic [7:0]  rx_in;
        logic [7:0]  rx_head;
        logic        rx_empty;
        logic        rx_full;
        logic        tx_push;
        logic        tx_pop;
        logic [7:0]  tx_head;
        logic        tx_empty;
        logic        tx_full;
        logic        rx_irq_q;
        logic        tx_irq_q;
        logic [15:0] rd_word;

        assign off    = io.bus_addr[2:1];
        assign rd_sel = io.bus_rd && chan_hit[g];
        // High-byte writes land on no register bits.
        assign wr_lo  = io.bus_wr && chan_hit[g] && !(io.bus_byte && io.bus_addr[0]);

`ifdef DLART_LOOPBACK_EN
        always_ff @(posedge clk_x2) begin
            if (!rstb)
                maint <= 1'b0;
            else if (wr_lo && off == 2'd2)
                maint <= io.bus_wdata[2];
        end
        assign loop = maint && !tx_empty && !rx_full;
`else
        assign maint = 1'b0;
        assign loop  = 1'b0;
`endif

        assign rx_push = (io.h_rx_valid[g] && rx_ready_v[g]) || loop;
        assign rx_in   = loop ? tx_head : io.h_rx_data[8*g +: 8];
        assign rx_pop  = rd_sel && off == 2'd1;
        assign tx_push = wr_lo && off == 2'd3;
        assign tx_pop  = (tx_valid_v[g] && io.h_tx_ready[g]) || loop;

        dlart_fifo #(.DEPTH(RX_DEPTH)) u_rx (
            .clk_x2   (clk_x2),
            .rstb     (rstb),
            .push     (rx_push),
            .push_dat (rx_in),
            .pop      (rx_pop),
            .head     (rx_head),
            .empty    (rx_empty),
            .full     (rx_full)
        );

        dlart_fifo #(.DEPTH(TX_DEPTH)) u_tx (
            .clk_x2   (clk_x2),
            .rstb     (rstb),
            .push     (tx_push),
            .push_dat (io.bus_wdata[7:0]),
            .pop      (tx_pop),
            .head     (tx_head),
            .empty    (tx_empty),
            .full     (tx_full)
        );

        assign rx_ready_v[g]         = rstb && !rx_full && !maint;
        assign tx_valid_v[g]         = !tx_empty && !maint;
        assign tx_data_v[8*g +: 8]   = tx_head;
        assign rx_irq_v[g]           = rx_irq_q;
        assign tx_irq_v[g]           = tx_irq_q;

        always_ff @(posedge clk_x2) begin
            if (!rstb) begin
                rie      <= 1'b0;
                xie      <= 1'b0;
                rx_irq_q <= 1'b0;
                tx_irq_q <= 1'b0;
            end else begin
                if (wr_lo && off == 2'd0)
                    rie <= io.bus_wdata[6];
                if (wr_lo && off == 2'd2)
                    xie <= io.bus_wdata[6];
                rx_irq_q <= rie && !rx_empty;
                tx_irq_q <= xie && !tx_full;
            end
        end

        always_comb begin
            rd_word = '0;
            case (off)
                2'd0:    rd_word = {8'h00, !rx_empty, rie, 6'b000000};
                2'd1:    rd_word = {8'h00, rx_empty ? 8'h00 : rx_head};
                2'd2:    rd_word = {8'h00, !tx_full, xie, 3'b000, maint, 2'b00};
                default: rd_word = '0;
            endcase
        end

        assign rd_words[16*g +: 16] = rd_word;
    end
endmodule

// File: doc/dlart_multi.md
Name: dlart_multi

Overview:
- N-channel DL11-style console/serial unit for the DCJ11 TangNano board.
- Generalises the single-byte RCSR/RBUF/XCSR/XBUF console path to NCH channels, each with RX/TX FIFOs and per-channel interrupt requests.
- CPU side is a decoded, registered register-access port, driven by the bus front-end after address latch. Host side uses byte-wide valid/ready links toward the ODT/host microcontroller.

Parameters:
- NCH, 1, number of channels (1..8).
- BASE, 22'o17777560, byte address of channel 0 RCSR.
- STRIDE, 8, byte spacing between channel register blocks.
- RX_DEPTH, 4, RX FIFO entries per channel (power of 2, >=2).
- TX_DEPTH, 4, TX FIFO entries per channel (power of 2, >=2).

Ports:
- clk_x2 input 1: clock, 36 MHz.
- rstb input 1: reset, synchronous, active-low.
- bus_addr input 22: latched physical byte address.
- bus_rd input 1: one-cycle read strobe.
- bus_wr input 1: one-cycle write strobe.
- bus_byte input 1: byte write when 1, word write when 0.
- bus_wdata input 16: write data.
- bus_rdata output 16: read data, registered.
- bus_hit output 1: address decoded to this block, registered with bus_rdata.
- rx_irq output NCH: receiver interrupt request per channel.
- tx_irq output NCH: transmitter interrupt request per channel.
- h_rx_valid input NCH: host offers byte to channel.
- h_rx_data input 8*NCH: host byte; channel n uses bits [8n+7:8n].
- h_rx_ready output NCH: channel RX FIFO can accept.
- h_tx_valid output NCH: channel has byte for host.
- h_tx_data output 8*NCH: TX FIFO head byte.
- h_tx_ready input NCH: host accepts byte.

Behaviour:
- Reset (rstb=0 at clk_x2 edge):
  - All FIFOs empty; RIE/XIE cleared.
  - bus_rdata=0, bus_hit=0, rx_irq=0, tx_irq=0, h_tx_valid=0, h_rx_ready=0 during reset.
  - Reset mid-transfer discards queued bytes; h_tx_valid drops the same edge.
- Decode:
  - Channel c hits when bus_addr in [BASE+c*STRIDE, BASE+c*STRIDE+7].
  - Offset = bus_addr[2:1]: 0 RCSR, 1 RBUF, 2 XCSR, 3 XBUF.
  - No hit: bus_hit=0, bus_rdata=0, no side effects.
- Read latency: bus_rd at cycle T gives bus_rdata/bus_hit valid at T+1 for exactly one cycle, then return to 0.
- RCSR: bit7 RDONE = RX FIFO non-empty (RO); bit6 RIE (RW); all other bits read 0.
- RBUF read:
  - Returns {8'b0, head byte} and pops.
  - Empty RX FIFO returns 0 and does not pop.
  - Writes to RBUF are ignored.
- XCSR: bit7 XRDY = TX FIFO not full (RO); bit6 XIE (RW); other bits 0 (bit2, see Optional Feature).
- XBUF write:
  - Pushes bus_wdata[7:0].
  - Write to full FIFO is dropped silently.
  - XBUF reads return 0.
- Byte writes:
  - bus_addr[0]=0 updates register low byte.
  - bus_addr[0]=1 (high byte) has no effect on any register.
- Host RX link:
  - h_rx_ready[c] = !rx_full[c], combinational from FIFO state.
  - Push occurs when valid&ready at a clk_x2 edge.
- Host TX link:
  - h_tx_valid[c] = TX FIFO non-empty; h_tx_data = head byte.
  - Pop occurs on valid&ready.
- FIFOs:
  - Pointers one bit wider than log2(depth); wrap naturally.
  - full = pointers differ only in MSB; empty = pointers equal.
- Simultaneous events:
  - Same-cycle push and pop both occur; count unchanged.
  - RBUF read on a full FIFO frees one slot; h_rx_ready rises the next cycle.
  - XBUF write on a full FIFO while the host pops the same cycle is still dropped (full sampled before pop).
- Interrupts:
  - rx_irq[c] = RIE & RDONE; tx_irq[c] = XIE & XRDY.
  - Both registered, one-cycle lag, level-sensitive.
  - Setting IE while the done/ready bit is already 1 asserts the irq the next cycle.
- bus_rd and bus_wr asserted together: write takes effect, read data reflects pre-write state.

Optional Feature:
- DLART_LOOPBACK_EN defined:
  - XCSR bit2 MAINT is RW, reset 0.
  - MAINT=1 routes the TX FIFO head into the channel's own RX FIFO whenever TX is non-empty and RX is not full (one byte per cycle).
  - While MAINT=1, h_tx_valid[c]=0 and h_rx_ready[c]=0.
- Not defined: bit2 reads 0, writes ignored, no loopback logic.

Test Plan:
- Reset, then read 17777560 and 17777564 -> bus_hit=1 at T+1; RCSR=16'o000000; XCSR=16'o000200.
- Host pushes 8'h41, 8'h42 on ch0 -> RCSR=16'o000200; RBUF reads 16'h0041 then 16'h0042; third RBUF read returns 0; RDONE clears.
- TX_DEPTH=4 with h_tx_ready=0: write XBUF five times with 1..5 -> XRDY=0 after four writes; host then receives 1,2,3,4 in order; 5 is lost.
- Write RCSR=16'o000100 while RX is empty -> rx_irq[0]=0; host pushes 8'h0D -> rx_irq[0]=1 within 2 cycles; RBUF read -> rx_irq[0]=0.
- NCH=2, STRIDE=8: host sends 8'h55 to ch1 -> readable at 17777572 only; ch0 RCSR RDONE stays 0; read at 17777600 gives bus_hit=0.
- With DLART_LOOPBACK_EN: XCSR=16'o000004, write XBUF=8'h7E -> RBUF reads 16'h007E; h_tx_valid stays 0 throughout.
